// File: rtl/fifo_to_ftdi_burst_ctrl_pkg.sv
// Shared definitions for the FTDI burst read path: FSM encoding, sizing helper
// and the default burst/threshold constants also used by the write-side controller.
package fifo_to_ftdi_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } burst_state_t;

  localparam int DEFAULT_BURST_LEN      = 1024;
  localparam int DEFAULT_RX_THRESH      = 1024;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_to_ftdi_burst_ctrl_idle_timer.sv
// Saturating idle counter; expired flags the last idle cycle before a flush is due.
module ftdi_idle_timer
  import fifo_to_ftdi_burst_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int SAT   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TMR_W = (clog2(SAT + 1) < 1) ? 1 : clog2(SAT + 1);
  localparam logic [TMR_W-1:0] SAT_V = TMR_W'(SAT);

  logic [TMR_W-1:0] tmr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (clr) begin
      tmr_q <= '0;
    end else if (en && (tmr_q != SAT_V)) begin
      tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && (tmr_q == SAT_V);

endmodule

// File: rtl/fifo_to_ftdi_burst_ctrl.sv
// Read-side burst controller: drains the stream FIFO towards the FTDI transmit path
// in fixed bursts, flushing residual data after an idle timeout.
module fifo_to_ftdi_burst_ctrl
  import fifo_to_ftdi_burst_ctrl_pkg::*;
#(
  parameter int USEDW_W        = 11,
  parameter int BURST_LEN      = DEFAULT_BURST_LEN,
  parameter int RX_THRESH      = DEFAULT_RX_THRESH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int BCNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic               ftdi_rx_rdy,
  input  logic               abort,
  input  logic               err_clr,
  output logic               fifo_rdreq,
  output logic               fifo_tx_rdy,
  output logic               fifo_rx_rdy,
  output logic               burst_done,
  output logic               burst_is_flush,
  output logic [BCNT_W-1:0]  burst_count,
  output logic               err_underflow
);

  localparam int CNT_W = clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]   BURST_LEN_C = CNT_W'(BURST_LEN);
  // One extra bit so BURST_LEN = 2^USEDW_W still compares correctly.
  localparam logic [USEDW_W:0]   BURST_LEN_U = (USEDW_W + 1)'(BURST_LEN);
  localparam logic [USEDW_W:0]   RX_THRESH_U = (USEDW_W + 1)'(RX_THRESH);

  burst_state_t      state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [BCNT_W-1:0] count_q, count_d;
  logic              done_q, done_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic              tx_rdy_q;

  logic usedw_ge_burst, burst_ready, active, cnt_lt_tgt, underflow, rdreq, expired;

  assign usedw_ge_burst = ({1'b0, fifo_usedw} >= BURST_LEN_U);
  assign burst_ready    = usedw_ge_burst || fifo_full;
  assign fifo_rx_rdy    = ({1'b0, fifo_usedw} < RX_THRESH_U) && !fifo_full;
  assign active         = (state_q != ST_IDLE);
  assign cnt_lt_tgt     = (byte_cnt_q < target_q);
  assign underflow      = active && ftdi_rx_rdy && cnt_lt_tgt && fifo_empty;
  assign rdreq          = active && ftdi_rx_rdy && cnt_lt_tgt && !fifo_empty && !abort;

  ftdi_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fifo_empty || active),
    .en     (!active && !fifo_empty),
    .expired(expired)
  );

  // NOTE: every signal gets its hold value first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    target_d   = target_q;
    count_d    = count_q;
    done_d     = 1'b0;
    flush_d    = flush_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        byte_cnt_d = '0;
        if (burst_ready) begin
          state_d  = ST_BURST;
          target_d = BURST_LEN_C;
        end else if (expired && !fifo_empty) begin
          state_d  = ST_FLUSH;
          target_d = usedw_ge_burst ? BURST_LEN_C : CNT_W'(fifo_usedw);
        end
      end
      ST_BURST, ST_FLUSH: begin
        if (abort) begin
          state_d    = ST_IDLE;
          byte_cnt_d = '0;
        end else if (rdreq) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q + CNT_W'(1) == target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            flush_d = (state_q == ST_FLUSH);
            count_d = count_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Setting wins over a simultaneous clear so no underflow event is lost.
    if (underflow)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      target_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      tx_rdy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      target_q   <= target_d;
      count_q    <= count_d;
      done_q     <= done_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
      tx_rdy_q   <= (state_d != ST_IDLE);
    end
  end

  assign fifo_rdreq     = rdreq;
  assign fifo_tx_rdy    = tx_rdy_q;
  assign burst_done     = done_q;
  assign burst_is_flush = flush_q;
  assign burst_count    = count_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_fifo_to_ftdi_burst_ctrl.sv
// Self-checking bench for fifo_to_ftdi_burst_ctrl with BURST_LEN=16, TIMEOUT_CYCLES=8.
module tb_fifo_to_ftdi_burst_ctrl;

  localparam int USEDW_W   = 5;
  localparam int BURST_LEN = 16;
  localparam int RX_THRESH = 12;
  localparam int TIMEOUT   = 8;
  localparam int BCNT_W    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_empty, fifo_full, ftdi_rx_rdy, abort, err_clr;
  logic               fifo_rdreq, fifo_tx_rdy, fifo_rx_rdy, burst_done, burst_is_flush;
  logic [BCNT_W-1:0]  burst_count;
  logic               err_underflow;

  fifo_to_ftdi_burst_ctrl #(
    .USEDW_W(USEDW_W), .BURST_LEN(BURST_LEN), .RX_THRESH(RX_THRESH),
    .TIMEOUT_CYCLES(TIMEOUT), .BCNT_W(BCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_usedw(fifo_usedw), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .ftdi_rx_rdy(ftdi_rx_rdy), .abort(abort), .err_clr(err_clr),
    .fifo_rdreq(fifo_rdreq), .fifo_tx_rdy(fifo_tx_rdy), .fifo_rx_rdy(fifo_rx_rdy),
    .burst_done(burst_done), .burst_is_flush(burst_is_flush), .burst_count(burst_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          reads;
    logic        flush;
    logic [3:0]  count;
  } done_t;

  typedef struct {
    logic [USEDW_W-1:0] usedw;
    logic               full;
    logic               exp_rx;
  } vec_t;

  done_t exp_q[$];
  done_t obs_q[$];
  int    rd_total = 0;
  int    tx_total = 0;
  int    checks   = 0;
  int    errors   = 0;
  int    exp_reads = 0;

  // Completion monitor: records the running read total at each burst_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rdreq)  rd_total = rd_total + 1;
      if (fifo_tx_rdy) tx_total = tx_total + 1;
      if (burst_done)  obs_q.push_back('{rd_total, burst_is_flush, burst_count});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_usedw = '0; fifo_empty = 1'b1; fifo_full = 1'b0; abort = 1'b0; ftdi_rx_rdy = 1'b1;
    repeat (2) tick();
  endtask

  task automatic start_burst();
    fifo_usedw = 5'd16; fifo_empty = 1'b0; fifo_full = 1'b0; ftdi_rx_rdy = 1'b1;
    tick();
    fifo_usedw = '0;
  endtask

  task automatic expect_done(input string tag, input int budget);
    int n;
    done_t o, e;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(obs_q.size() != 0), 1);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_reads"}, o.reads, e.reads);
      check({tag, "_is_flush"}, 32'(o.flush), 32'(e.flush));
      check({tag, "_count"}, 32'(o.count), 32'(e.count));
      check({tag, "_done_pulse"}, 32'(burst_done), 0);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   tx0, n;

    vecs[0] = '{5'd0,  1'b0, 1'b1};
    vecs[1] = '{5'd11, 1'b0, 1'b1};
    vecs[2] = '{5'd12, 1'b0, 1'b0};
    vecs[3] = '{5'd31, 1'b0, 1'b0};
    vecs[4] = '{5'd0,  1'b1, 1'b0};
    vecs[5] = '{5'd5,  1'b1, 1'b0};
    vecs[6] = '{5'd16, 1'b0, 1'b0};

    rst_n = 1'b0; fifo_usedw = '0; fifo_empty = 1'b1; fifo_full = 1'b0;
    ftdi_rx_rdy = 1'b0; abort = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_rdreq", 32'(fifo_rdreq), 0);
    check("rst_tx_rdy", 32'(fifo_tx_rdy), 0);
    check("rst_done", 32'(burst_done), 0);
    check("rst_count", 32'(burst_count), 0);
    check("rst_err", 32'(err_underflow), 0);
    rst_n = 1'b1;
    tick();

    // Combinational fifo_rx_rdy in IDLE; inputs restored before the next edge.
    for (int i = 0; i < 7; i++) begin
      fifo_usedw = vecs[i].usedw;
      fifo_full  = vecs[i].full;
      #1;
      check($sformatf("vec%0d_rx_rdy", i), 32'(fifo_rx_rdy), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_rdreq", i), 32'(fifo_rdreq), 0);
      fifo_usedw = '0;
      fifo_full  = 1'b0;
    end
    tick();

    // Full burst: 15 words is not enough, 16 starts the burst next cycle.
    fifo_usedw = 5'd15; fifo_empty = 1'b0; ftdi_rx_rdy = 1'b1;
    tick();
    check("full_no_burst_15", 32'(fifo_tx_rdy), 0);
    fifo_usedw = 5'd16;
    tx0 = tx_total;
    tick();
    check("full_tx_rdy", 32'(fifo_tx_rdy), 1);
    check("full_first_rd", 32'(fifo_rdreq), 1);
    fifo_usedw = '0;
    exp_reads += 16;
    exp_q.push_back('{exp_reads, 1'b0, 4'd1});
    expect_done("full", 40);
    check("full_tx_cycles", tx_total - tx0, 16);
    idle();

    // Backpressure: ftdi_rx_rdy alternates 1/0 from the first burst cycle.
    tx0 = tx_total;
    start_burst();
    exp_reads += 16;
    exp_q.push_back('{exp_reads, 1'b0, 4'd2});
    for (int i = 0; i < 80; i++) begin
      tick();
      if (obs_q.size() != 0) break;
      ftdi_rx_rdy = ~ftdi_rx_rdy;
    end
    ftdi_rx_rdy = 1'b1;
    expect_done("bp", 4);
    check("bp_tx_cycles", tx_total - tx0, 31);
    idle();

    // Flush: 5 words held, no burst_ready, timeout of 8 idle cycles.
    fifo_usedw = 5'd5; fifo_empty = 1'b0;
    n = 0;
    while (!fifo_tx_rdy && n < 20) begin
      tick();
      n++;
    end
    check("flush_start_delay", n, 8);
    exp_reads += 5;
    exp_q.push_back('{exp_reads, 1'b1, 4'd3});
    expect_done("flush", 20);
    idle();

    // Abort after 6 reads, then a fresh full burst.
    start_burst();
    repeat (6) tick();
    abort = 1'b1;
    #1;
    check("abort_rd_suppressed", 32'(fifo_rdreq), 0);
    tick();
    abort = 1'b0;
    exp_reads += 6;
    check("abort_to_idle", 32'(fifo_tx_rdy), 0);
    check("abort_count_held", 32'(burst_count), 3);
    idle();
    check("abort_no_done", 32'(obs_q.size()), 0);
    check("abort_reads", rd_total, exp_reads);
    start_burst();
    exp_reads += 16;
    exp_q.push_back('{exp_reads, 1'b0, 4'd4});
    expect_done("post_abort", 40);
    idle();

    // Underflow: FIFO empties after 2 reads; burst waits, error is sticky.
    start_burst();
    repeat (2) tick();
    fifo_empty = 1'b1;
    #1;
    check("uf_rd_suppressed", 32'(fifo_rdreq), 0);
    tick();
    check("uf_err_set", 32'(err_underflow), 1);
    repeat (2) tick();
    check("uf_burst_waits", 32'(fifo_tx_rdy), 1);
    fifo_empty = 1'b0;
    exp_reads += 16;
    exp_q.push_back('{exp_reads, 1'b0, 4'd5});
    expect_done("uf", 40);
    check("uf_err_sticky", 32'(err_underflow), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("uf_err_cleared", 32'(err_underflow), 0);
    idle();

    // Reset mid-burst, then fifo_full with usedw=0 alone starts a burst.
    start_burst();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    exp_reads += 3;
    check("mid_rst_rdreq", 32'(fifo_rdreq), 0);
    check("mid_rst_tx_rdy", 32'(fifo_tx_rdy), 0);
    check("mid_rst_count", 32'(burst_count), 0);
    check("mid_rst_done", 32'(burst_done), 0);
    fifo_usedw = '0; fifo_full = 1'b1; fifo_empty = 1'b0;
    repeat (2) tick();
    check("in_rst_tx_rdy", 32'(fifo_tx_rdy), 0);
    check("in_rst_rdreq", 32'(fifo_rdreq), 0);
    rst_n = 1'b1;
    tick();
    check("wrap_tx_rdy", 32'(fifo_tx_rdy), 1);
    check("wrap_rdreq", 32'(fifo_rdreq), 1);
    check("rst_no_done", 32'(obs_q.size()), 0);
    fifo_full = 1'b0;
    exp_reads += 16;
    exp_q.push_back('{exp_reads, 1'b0, 4'd1});
    expect_done("wrap", 40);
    idle();

    check("sb_obs_drained", 32'(obs_q.size()), 0);
    check("sb_exp_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_to_ftdi_burst_ctrl.md
# fifo_to_ftdi_burst_ctrl

Parametrised read-side controller between the stream FIFO and the FTDI transmit path. It issues `fifo_rdreq` in fixed-length bursts of `BURST_LEN` words once enough data is buffered. After an idle timeout it flushes a partial burst so residual data does not stall in the FIFO. It also supports abort, an underflow guard with a sticky error, and burst accounting.

## Interface
Parameters:
- `USEDW_W`, 11: width of `fifo_usedw`.
- `BURST_LEN`, 1024: words per full burst. Range 1..2^USEDW_W.
- `RX_THRESH`, 1024: upstream write-enable threshold.
- `TIMEOUT_CYCLES`, 4096: idle cycles with a non-empty FIFO before a flush burst starts. 0 disables flush.
- `BCNT_W`, 16: width of `burst_count`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_usedw` in USEDW_W: FIFO fill level.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_full` in 1: FIFO full flag.
- `ftdi_rx_rdy` in 1: FTDI side accepts a word this cycle.
- `abort` in 1: synchronous burst abort.
- `err_clr` in 1: clears `err_underflow`.
- `fifo_rdreq` out 1: FIFO read strobe; one word per asserted cycle.
- `fifo_tx_rdy` out 1: a burst is active; registered.
- `fifo_rx_rdy` out 1: upstream may write; combinational.
- `burst_done` out 1: one-cycle pulse after the last word of a burst.
- `burst_is_flush` out 1: qualifies `burst_done`; 1 means the burst was a partial flush.
- `burst_count` out BCNT_W: completed bursts, wraps modulo 2^BCNT_W.
- `err_underflow` out 1: sticky underflow flag.

## Operation
- Widths:
  - `CNT_W` = clog2(BURST_LEN+1).
  - `target` and `byte_cnt` are CNT_W wide.
- `fifo_rx_rdy` = (`fifo_usedw` < RX_THRESH) and not `fifo_full`.
- `burst_ready` = (`fifo_usedw` >= BURST_LEN) or `fifo_full`.
- States:
  - IDLE:
    - `fifo_tx_rdy`=0 and `byte_cnt`=0.
    - `idle_tmr` counts cycles while `fifo_empty`=0. It clears when the FIFO is empty or the FSM leaves IDLE, and saturates.
    - If `burst_ready`: go to BURST with `target`=BURST_LEN. This has priority over flush.
    - Else if TIMEOUT_CYCLES>0, `idle_tmr`==TIMEOUT_CYCLES-1 and not `fifo_empty`: go to FLUSH with `target`=min(`fifo_usedw`, BURST_LEN), latched at that edge.
  - BURST / FLUSH:
    - `fifo_tx_rdy`=1.
    - `fifo_rdreq` = `ftdi_rx_rdy` & (`byte_cnt` < `target`) & ~`fifo_empty` & ~`abort`.
    - `byte_cnt` increments on each `fifo_rdreq`.
    - On the edge where the read brings `byte_cnt` to `target`: return to IDLE. At that same edge, `burst_done`=1 for the next cycle, `burst_is_flush` reflects the state, and `burst_count` increments.
    - `abort`=1: return to IDLE at the next edge. No `burst_done`, no count increment.
- Underflow:
  - Set `err_underflow` when in BURST/FLUSH with `ftdi_rx_rdy`=1, `byte_cnt` < `target` and `fifo_empty`=1.
  - The read is suppressed; the burst waits.
  - `err_clr` clears the flag. If set and clear conditions occur in the same cycle, set wins.
- Simultaneous events:
  - `abort` in the final-read cycle: the abort wins and the read is suppressed.
  - `ftdi_rx_rdy` deasserted mid-burst: hold state and count. There is no timeout inside a burst.

## Timing
- Reset values (asynchronous): state=IDLE; all registered outputs 0; `byte_cnt`, `idle_tmr` and `target` are 0.
- `fifo_tx_rdy` rises 1 cycle after `burst_ready` is sampled in IDLE.
- The first `fifo_rdreq` can occur in that same cycle.
- A full burst with `ftdi_rx_rdy` held high:
  - `fifo_tx_rdy` is high for exactly BURST_LEN cycles.
  - `fifo_rdreq` is high for exactly BURST_LEN cycles.
  - `burst_done` follows in the first IDLE cycle.
- Minimum gap between bursts: 1 IDLE cycle.
- Flush start: TIMEOUT_CYCLES cycles after the FIFO becomes non-empty in IDLE.
- Reset asserted mid-burst: the FSM drops to IDLE immediately and `fifo_rdreq` goes low combinationally. No completion is reported.

## Structure
- Shared package holds:
  - State encoding (IDLE, BURST, FLUSH).
  - `clog2` function.
  - Default BURST_LEN and threshold constants shared with the write-side controller.
- Sub-module `ftdi_idle_timer`: saturating counter with clear, enable and `expired` outputs; parametrised by TIMEOUT_CYCLES.
- All remaining logic stays in a single FSM.

## Test plan
- Full burst: BURST_LEN=16, `fifo_usedw` 15→16, `ftdi_rx_rdy`=1 → `fifo_tx_rdy` after 1 cycle, 16 `fifo_rdreq` cycles, one `burst_done` with `burst_is_flush`=0, `burst_count`=1.
- Backpressure: toggle `ftdi_rx_rdy` 1/0 during a burst → exactly 16 reads; `fifo_tx_rdy` is high for 31 cycles.
- Flush: TIMEOUT_CYCLES=8, `fifo_usedw`=5 held → FLUSH after 8 cycles, 5 reads, `burst_done` with `burst_is_flush`=1.
- Abort after 6 reads → IDLE next cycle, no `burst_done`, `burst_count` unchanged; the next burst starts a fresh count from 0.
- Underflow: force `fifo_empty`=1 mid-burst → `fifo_rdreq`=0, `err_underflow`=1 and it persists until `err_clr`.
- Reset mid-burst and `fifo_full` with `fifo_usedw`=0 (wrap case) → all outputs are 0 during reset; the full flag alone triggers BURST afterwards.
